// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and types for the SPI NOR flash sequencer.
//   - flash opcodes issued to spi_master_fl
//   - spi_master_fl commtype encodings
//   - req_op encodings, FSM state enumeration, step-table entry type
package spi_flash_pkg;

  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDSR = 8'h05;
  localparam logic [7:0] OPC_RDID = 8'h9F;

  localparam logic [2:0] CT_CMD_ONLY  = 3'b000;
  localparam logic [2:0] CT_RD_REG    = 3'b001;
  localparam logic [2:0] CT_RD_DATA   = 3'b010;
  localparam logic [2:0] CT_RSVD      = 3'b011;
  localparam logic [2:0] CT_WR_DATA   = 3'b100;
  localparam logic [2:0] CT_ADDR_ONLY = 3'b101;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_PROGRAM = 2'b01,
    OP_ERASE   = 2'b10,
    OP_READ_ID = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [2:0] ctype;
    logic       poll;   // status poll step, repeated while WIP=1
    logic       last;   // final step of the operation
  } step_t;

  // Transaction types that return a word through validflag_out
  function automatic logic is_answer(input logic [2:0] ct);
    return (ct == CT_RD_REG) || (ct == CT_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_flash_sequencer_if.sv
// spi_flash_sequencer_if: CPU-side request/response bus plus the command and
// result signals of spi_master_fl.
//   slave  : sequencer view (takes requests, drives the master's command inputs)
//   master : environment view (CPU bank issuing requests, spi_master_fl answering)
interface spi_flash_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        m_valid;
  logic [7:0]  m_command;
  logic [23:0] m_address;
  logic [31:0] m_data;
  logic [2:0]  m_commtype;
  logic        m_tready;
  logic        m_valid_out;
  logic [31:0] m_data_out;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  m_tready, m_valid_out, m_data_out,
    output req_ready, resp_valid, resp_data, resp_err,
    output m_valid, m_command, m_address, m_data, m_commtype
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output m_tready, m_valid_out, m_data_out,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  m_valid, m_command, m_address, m_data, m_commtype
  );
endinterface

// File: rtl/spi_seq_timer.sv
// spi_seq_timer: saturating down-counter for wait-state timeouts.
//   clk, rst : clock, async active-high reset
//   clear    : reload to LOAD_VAL (restarts the timeout window)
//   en       : count down one per cycle, stops at zero
//   expired  : terminal count reached (counter is zero)
module spi_seq_timer #(
  parameter int unsigned LOAD_VAL = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = $clog2(LOAD_VAL + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= W'(LOAD_VAL);
    else if (clear)
      cnt <= W'(LOAD_VAL);
    else if (en && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: turns one high-level flash request into the ordered
// spi_master_fl transactions (WREN, operation, RDSR polling) and returns the
// read data / last status word with an error flag.
//   clk, rst : clock, async active-high reset (shared with spi_master_fl)
//   bus      : request/response bus and master command/result signals
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   S_IDLE      | req_ready=1, latch request on req_valid
//   S_ISSUE     | m_valid pulse with current step's command/type
//   S_WAIT_BUSY | wait for master tready to drop (it lags the pulse)
//   S_WAIT_DONE | wait for tready high (+ answer word for read types)
//   S_NEXT      | repeat poll while WIP, advance step, or finish
//   S_DONE      | resp_valid pulse
module spi_flash_sequencer
  import spi_flash_pkg::*;
#(
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_sequencer_if.slave  bus
);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  state_e        state, state_nxt;
  req_op_e       op_q;
  logic [23:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    idx_q;
  logic [PW-1:0] poll_cnt;
  logic          ans_flag;
  logic          err_q;
  logic          err_set;
  logic [31:0]   rdata_q;
  logic [7:0]    cmd_q;
  logic [2:0]    ct_q;
  logic [23:0]   maddr_q;
  logic [31:0]   mdata_q;
  logic          cap;
  logic          got_ans;
  logic          tmr_clear;
  logic          tmr_en;
  logic          tmr_expired;
  step_t         step;

  function automatic step_t step_lookup(input req_op_e op, input logic [1:0] idx);
    step_t s;
    s = '{cmd: OPC_RDSR, ctype: CT_RD_REG, poll: 1'b1, last: 1'b1};
    case (op)
      OP_READ:    s = '{cmd: OPC_READ, ctype: CT_RD_DATA, poll: 1'b0, last: 1'b1};
      OP_READ_ID: s = '{cmd: OPC_RDID, ctype: CT_RD_REG,  poll: 1'b0, last: 1'b1};
      default: begin
        case (idx)
          2'd0: s = '{cmd: OPC_WREN, ctype: CT_CMD_ONLY, poll: 1'b0, last: 1'b0};
          2'd1: s = (op == OP_PROGRAM)
                    ? '{cmd: OPC_PP, ctype: CT_WR_DATA,   poll: 1'b0, last: 1'b0}
                    : '{cmd: OPC_SE, ctype: CT_ADDR_ONLY, poll: 1'b0, last: 1'b0};
          default: s = '{cmd: OPC_RDSR, ctype: CT_RD_REG, poll: 1'b1, last: 1'b1};
        endcase
      end
    endcase
    return s;
  endfunction

  assign step = step_lookup(op_q, idx_q);

  // An answer arriving in the same cycle as tready rises still counts
  assign cap     = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && bus.m_valid_out;
  assign got_ans = ans_flag || cap;
  assign tmr_en  = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

  spi_seq_timer #(.LOAD_VAL(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    tmr_clear = 1'b0;
    case (state)
      S_IDLE:
        if (bus.req_valid) state_nxt = S_ISSUE;
      S_ISSUE: begin
        state_nxt = S_WAIT_BUSY;
        tmr_clear = 1'b1;
      end
      S_WAIT_BUSY:
        if (!bus.m_tready) begin
          state_nxt = S_WAIT_DONE;
          tmr_clear = 1'b1;
        end else if (tmr_expired) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      S_WAIT_DONE:
        if (bus.m_tready && (!is_answer(step.ctype) || got_ans)) begin
          state_nxt = S_NEXT;
        end else if (tmr_expired) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end
      S_NEXT:
        if (step.poll && rdata_q[24]) begin
          // poll_cnt increments this cycle; reaching POLL_MAX ends the operation
          if (poll_cnt == PW'(POLL_MAX - 1)) begin
            state_nxt = S_DONE;
            err_set   = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
          end
        end else if (!step.last) begin
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_DONE;
        end
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      poll_cnt <= '0;
      ans_flag <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cmd_q    <= '0;
      ct_q     <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.req_valid) begin
            op_q     <= req_op_e'(bus.req_op);
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            idx_q    <= '0;
            poll_cnt <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
          end
        S_ISSUE: begin
          cmd_q    <= step.cmd;
          ct_q     <= step.ctype;
          maddr_q  <= addr_q;
          mdata_q  <= wdata_q;
          ans_flag <= 1'b0;
        end
        S_NEXT:
          if (step.poll && rdata_q[24]) begin
            if (poll_cnt != PW'(POLL_MAX)) poll_cnt <= poll_cnt + PW'(1);
          end else if (!step.last) begin
            idx_q <= idx_q + 2'd1;
          end
        default: ;
      endcase
      if (cap) begin
        rdata_q  <= bus.m_data_out;
        ans_flag <= 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  // Command outputs show the step live during ISSUE, then hold it
  assign bus.m_valid    = (state == S_ISSUE);
  assign bus.m_command  = (state == S_ISSUE) ? step.cmd   : cmd_q;
  assign bus.m_commtype = (state == S_ISSUE) ? step.ctype : ct_q;
  assign bus.m_address  = (state == S_ISSUE) ? addr_q     : maddr_q;
  assign bus.m_data     = (state == S_ISSUE) ? wdata_q    : mdata_q;

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_data  = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: randomized bench with a behavioural spi_master_fl
// model and a reference model that derives the expected transaction list,
// response word and error flag from the operation rules.
module tb_spi_flash_sequencer;
  localparam int POLL_MAX = 4;
  localparam int TIMEOUT  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_flash_sequencer_if bus();

  spi_flash_sequencer #(.POLL_MAX(POLL_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [23:0] addr;
    logic [31:0] data;
  } iss_t;

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] ct;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  iss_t        iss_q[$];
  logic [31:0] stat_q[$];
  int          resp_cnt = 0;
  logic [31:0] resp_data_s;
  logic        resp_err_s;
  int          acc_cyc, first_mv_cyc, mv_cyc, resp_cyc, rise_cyc;
  bit          stuck_ready = 1'b0;
  logic [31:0] rd_word, id_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // monitor + spi_master_fl model, both on the falling edge
  initial begin
    int   phase, dly;
    bit   ans;
    logic [31:0] ans_word;
    phase = 0; dly = 0; ans = 1'b0; ans_word = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.m_valid) begin
          iss_q.push_back('{bus.m_command, bus.m_commtype, bus.m_address, bus.m_data});
          mv_cyc = cyc;
          if (first_mv_cyc < 0) first_mv_cyc = cyc;
        end
        if (bus.resp_valid) begin
          resp_cnt++;
          resp_cyc    = cyc;
          resp_data_s = bus.resp_data;
          resp_err_s  = bus.resp_err;
        end
      end
      if (rst) begin
        phase = 0;
        bus.m_tready    = 1'b1;
        bus.m_valid_out = 1'b0;
      end else begin
        bus.m_valid_out = 1'b0;
        bus.m_data_out  = $urandom;
        case (phase)
          0: if (bus.m_valid && !stuck_ready) begin
               ans = (bus.m_commtype == 3'b001) || (bus.m_commtype == 3'b010);
               if (bus.m_command == 8'h05) begin
                 if (stat_q.size() > 0) ans_word = stat_q.pop_front();
                 else ans_word = '0;
               end else if (bus.m_command == 8'h9F) ans_word = id_word;
               else ans_word = rd_word;
               dly = $urandom_range(0, 2);
               phase = 1;
             end
          1: if (dly == 0) begin
               bus.m_tready = 1'b0;
               dly = $urandom_range(1, 5);
               phase = 2;
             end else dly--;
          default: if (dly == 0) begin
               if (ans) begin
                 bus.m_valid_out = 1'b1;
                 bus.m_data_out  = ans_word;
               end
               bus.m_tready = 1'b1;
               rise_cyc = cyc;
               phase = 0;
             end else dly--;
        endcase
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_resp_data",  bus.resp_data,       32'd0);
    chk("rst_m_valid",    32'(bus.m_valid),    32'd0);
    chk("rst_m_command",  32'(bus.m_command),  32'd0);
    chk("rst_m_address",  32'(bus.m_address),  32'd0);
    chk("rst_m_data",     bus.m_data,          32'd0);
    chk("rst_m_commtype", 32'(bus.m_commtype), 32'd0);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    while (!bus.req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_addr  = 24'($urandom);
    bus.req_wdata = $urandom;
  endtask

  // nwip: number of status reads returning WIP=1 before a clear one
  task automatic run_op(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] wd,
                        input logic [31:0] ans, input int nwip, input bit stuck, input bit noise);
    exp_t        exp_q[$];
    logic [31:0] exp_data, w;
    logic        exp_err;
    int          npoll, r0, n;

    stat_q.delete();
    rd_word = ans;
    id_word = ans;
    exp_err = 1'b0;
    exp_data = ans;
    case (op)
      2'b00: exp_q.push_back('{8'h03, 3'b010});
      2'b11: exp_q.push_back('{8'h9F, 3'b001});
      default: begin
        exp_q.push_back('{8'h06, 3'b000});
        if (op == 2'b01) exp_q.push_back('{8'h02, 3'b100});
        else             exp_q.push_back('{8'h20, 3'b101});
        npoll = (nwip >= POLL_MAX) ? POLL_MAX : nwip + 1;
        exp_err = (nwip >= POLL_MAX);
        for (int i = 0; i < npoll; i++) begin
          w = $urandom;
          w[24] = (i < nwip);
          stat_q.push_back(w);
          exp_q.push_back('{8'h05, 3'b001});
          exp_data = w;
        end
      end
    endcase
    if (stuck) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      stat_q.delete();
      exp_err = 1'b1;
      exp_data = '0;
    end
    stuck_ready = stuck;
    iss_q.delete();
    first_mv_cyc = -1;
    r0 = resp_cnt;

    drive_req(op, addr, wd);
    if (noise) begin
      repeat (5) @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end

    n = 0;
    while (resp_cnt == r0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (resp_cnt == r0) chk("resp_valid_timeout", 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    #1;

    chk("resp_count",    32'(resp_cnt - r0), 32'd1);
    chk("ready_return",  32'(bus.req_ready), 32'd1);
    chk("resp_err",      32'(resp_err_s),    32'(exp_err));
    chk("resp_data",     resp_data_s,        exp_data);
    chk("issue_count",   32'(iss_q.size()),  32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < iss_q.size(); i++) begin
      chk("issue_cmd",  32'(iss_q[i].cmd),  32'(exp_q[i].cmd));
      chk("issue_type", 32'(iss_q[i].ct),   32'(exp_q[i].ct));
      chk("issue_addr", 32'(iss_q[i].addr), 32'(addr));
      if (exp_q[i].cmd == 8'h02) chk("issue_wdata", iss_q[i].data, wd);
    end
    chk("accept_to_mvalid", 32'(first_mv_cyc - acc_cyc), 32'd1);
    if (stuck)
      chk("timeout_latency", 32'(resp_cyc - mv_cyc), 32'(TIMEOUT + 2));
    else if (!exp_err)
      chk("tready_to_resp", 32'(resp_cyc - rise_cyc), 32'd2);
    stuck_ready = 1'b0;
  endtask

  initial begin
    int n;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.m_tready    = 1'b1;
    bus.m_valid_out = 1'b0;
    bus.m_data_out  = '0;
    first_mv_cyc = -1;
    acc_cyc = 0; mv_cyc = 0; resp_cyc = 0; rise_cyc = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_op(2'b00, 24'h001234, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    run_op(2'b01, 24'h000100, 32'hA5A5A5A5, $urandom, 2, 1'b0, 1'b0);
    run_op(2'b10, 24'($urandom), $urandom, $urandom, POLL_MAX, 1'b0, 1'b0);
    run_op(2'b00, 24'($urandom), $urandom, $urandom, 0, 1'b1, 1'b0);
    run_op(2'b01, 24'($urandom), $urandom, $urandom, 1, 1'b0, 1'b1);

    // reset in the middle of PROGRAM polling
    stat_q.delete();
    for (int i = 0; i < POLL_MAX; i++) stat_q.push_back(32'h0100_0000 | 32'($urandom_range(0, 255)));
    iss_q.delete();
    drive_req(2'b01, 24'h00ABCD, 32'h12345678);
    n = 0;
    while (iss_q.size() < 3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reset_reached_poll", 32'(iss_q.size() >= 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1 rst = 1'b0;
    stat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    run_op(2'b11, 24'($urandom), $urandom, $urandom, 0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++)
      run_op(2'($urandom_range(0, 3)), 24'($urandom), $urandom, $urandom,
             $urandom_range(0, POLL_MAX), 1'b0, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
